load_store_unit: RTL and testbench

- Data-memory access stage directly downstream of the ALU in the RV32I core.
- Takes the ALU-computed effective address and rs2 store data, and performs byte, half or word loads and stores over a req/ready handshake to data memory.
- Aligns and sign- or zero-extends load data for writeback, detects faults, and stalls the core while an access is in flight.

---
 rtl/load_store_unit.sv | 273 +++++++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
//   RV32I data-memory access stage, directly downstream of the ALU. It turns
//   the effective address and rs2 store data into a single word-aligned
//   req/ready transaction with byte enables. It extracts and extends load
//   data for writeback, flags illegal or misaligned accesses, and stalls the
//   core while an access is in flight.
//
//   Optional feature: define LSU_TIMEOUT_EN to add a watchdog. The watchdog
//   aborts a request after TIMEOUT cycles without dmem_ready. An aborted
//   access reports fault for one cycle and returns load_data = 0.
//
// Parameters
//   TIMEOUT_W   width of the watchdog counter (LSU_TIMEOUT_EN only)
//   TIMEOUT     REQ cycles without ready before abort (LSU_TIMEOUT_EN only)
//
// Ports
//   clk, rst        core clock (rising edge), asynchronous active-high reset
//   mem_read        current instruction is a load
//   mem_write       current instruction is a store
//   funct3          width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   alu_out         effective address
//   rs2_data        store data
//   stall           hold PC/regfile this cycle
//   load_data       extended load result, held until the next load
//   fault           access rejected (or aborted by the watchdog)
//   dmem_req        memory request
//   dmem_we         1 = write
//   dmem_addr       word address, bits [1:0] = 00
//   dmem_wdata      lane-replicated store data
//   dmem_be         byte enables
//   dmem_ready      memory accepts/completes the request
//   dmem_rdata      read word, valid with dmem_ready
module load_store_unit #(
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_out,
  input  logic [31:0] rs2_data,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        fault,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata
);

  // The watchdog compares against TIMEOUT, so TIMEOUT must be representable
  // in the counter.
  if (TIMEOUT < 1 || TIMEOUT > (2 ** TIMEOUT_W) - 1) begin : g_timeout_range
    $error("load_store_unit: TIMEOUT does not fit in TIMEOUT_W bits");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] load_data_q, load_data_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;

`ifdef LSU_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] CNT_ONE  = TIMEOUT_W'(1);
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT - 1);

  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 fault_q, fault_d;
`endif

  logic acc;
  logic req_valid;
  logic fault_idle;

  // Width/alignment legality for one access. Stores only allow B/H/W.
  function automatic logic access_ok(input logic       wr,
                                     input logic [2:0] f3,
                                     input logic [1:0] off);
    logic ok;
    case (f3)
      3'b000:  ok = 1'b1;
      3'b001:  ok = ~off[0];
      3'b010:  ok = (off == 2'b00);
      3'b100:  ok = ~wr;
      3'b101:  ok = ~wr & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3,
                                         input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate the store lane across the word so the memory only has to
  // honour the byte enables.
  function automatic logic [31:0] store_lanes(input logic [2:0]  f3,
                                              input logic [31:0] d);
    logic [31:0] w;
    case (f3[1:0])
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Pick the addressed lane out of the read word, then sign- or zero-extend.
  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [2:0]  f3);
    logic signed [7:0]  lane_b;
    logic signed [15:0] lane_h;
    logic [31:0]        res;
    lane_b = word[{off, 3'b000} +: 8];
    lane_h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  res = 32'(lane_b);
      3'b001:  res = 32'(lane_h);
      3'b100:  res = {24'd0, lane_b};
      3'b101:  res = {16'd0, lane_h};
      default: res = word;
    endcase
    return res;
  endfunction

  assign acc       = mem_read ^ mem_write;
  assign req_valid = acc & access_ok(mem_write, funct3, alu_out[1:0]);

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    load_data_d = load_data_q;
    f3_d        = f3_q;
    off_d       = off_q;
    stall       = 1'b0;
    fault_idle  = 1'b0;
`ifdef LSU_TIMEOUT_EN
    cnt_d       = cnt_q;
    fault_d     = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          stall   = 1'b1;
          req_d   = 1'b1;
          we_d    = mem_write;
          addr_d  = {alu_out[31:2], 2'b00};
          be_d    = byte_en(funct3, alu_out[1:0]);
          wdata_d = mem_write ? store_lanes(funct3, rs2_data) : 32'd0;
          f3_d    = funct3;
          off_d   = alu_out[1:0];
          state_d = REQ;
`ifdef LSU_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          // Both-high, illegal width or misalignment; no access is started.
          fault_idle = mem_read | mem_write;
        end
      end

      REQ: begin
        stall = 1'b1;
        if (dmem_ready) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = DONE;
          if (!we_q) begin
            load_data_d = extend_load(dmem_rdata, off_q, f3_q);
          end
`ifdef LSU_TIMEOUT_EN
        end else if (cnt_q == CNT_LAST) begin
          // The count reaches TIMEOUT this cycle. A ready in the same cycle
          // takes the branch above instead.
          req_d       = 1'b0;
          we_d        = 1'b0;
          state_d     = DONE;
          fault_d     = 1'b1;
          load_data_d = 32'd0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
`endif
        end
      end

      // The retiring instruction is still on the inputs here. They are
      // deliberately not sampled, so the access is not issued a second time.
      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      be_q        <= 4'd0;
      load_data_q <= 32'd0;
      f3_q        <= 3'd0;
      off_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      load_data_q <= load_data_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
    end
  end

`ifdef LSU_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  assign fault = fault_idle | fault_q;
`else
  assign fault = fault_idle;
`endif

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_be    = be_q;
  assign load_data  = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit. It runs directed scenarios plus
// randomized accesses. Expected values come from an arithmetic reference
// model of the access rules: sizes, alignment, lane shifts and sign
// extension.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] alu_out, rs2_data;
  logic        stall, fault;
  logic [31:0] load_data;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;

  load_store_unit #(.TIMEOUT_W(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .alu_out(alu_out), .rs2_data(rs2_data), .stall(stall),
    .load_data(load_data), .fault(fault), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] exp_ld;

  // Observations recorded by run_access for the calling test to judge.
  int          obs_stall;
  bit          obs_fault, obs_done, obs_req_seen, obs_unstable;
  bit          obs_done_fault, obs_req_done, obs_req_post;
  logic        obs_we;
  logic [31:0] obs_addr, obs_wdata, obs_ld;
  logic [3:0]  obs_be;

  // ---------------- reference model ----------------
  function automatic int ref_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit ref_valid(input bit rd, input bit wr,
                                   input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = ref_size(f3);
    if (rd == wr) return 1'b0;
    if (sz == 0) return 1'b0;
    if (wr && f3[2]) return 1'b0;
    return (int'(a[1:0]) % sz) == 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
    int m;
    m = ((1 << ref_size(f3)) - 1) << a[1:0];
    return m[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input bit wr, input logic [2:0] f3,
                                            input logic [31:0] d);
    if (!wr) return 32'd0;
    case (ref_size(f3))
      1:       return d[7:0] * 32'h0101_0101;
      2:       return d[15:0] * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rdata,
                                           input logic [2:0] f3, input logic [31:0] a);
    longint v, span;
    int     sz;
    sz   = ref_size(f3);
    span = longint'(1) << (8 * sz);
    v    = (longint'(rdata) >> (8 * int'(a[1:0]))) % span;
    if (!f3[2] && sz < 4 && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic clear_inputs();
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    funct3     = 3'd0;
    alu_out    = 32'd0;
    rs2_data   = 32'd0;
    dmem_ready = 1'b0;
  endtask

  // Presents one instruction and holds it until the unit releases the core.
  // The memory answers after wait_n REQ cycles; wait_n < 0 means it never
  // answers. A spurious ready is also driven during the retire cycle.
  task automatic run_access(input bit rd, input bit wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] rdata, input int wait_n,
                            input int budget);
    obs_stall = 0; obs_fault = 0; obs_done = 0; obs_req_seen = 0;
    obs_unstable = 0; obs_done_fault = 0; obs_req_done = 0; obs_req_post = 0;
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; funct3 = f3; alu_out = a; rs2_data = d;
    dmem_ready = 1'b0; dmem_rdata = $urandom;
    @(negedge clk);
    obs_fault = fault;
    if (!stall) begin
      obs_done = 1'b1;
    end else begin
      obs_stall = 1;
      for (int k = 0; k < budget; k++) begin
        @(posedge clk); #1;
        dmem_ready = (wait_n >= 0) && (k >= wait_n);
        dmem_rdata = (k == wait_n) ? rdata : $urandom;
        @(negedge clk);
        if (!stall) begin
          obs_done = 1'b1; obs_ld = load_data;
          obs_done_fault = fault; obs_req_done = dmem_req;
          break;
        end
        obs_stall++;
        if (!obs_req_seen) begin
          obs_req_seen = dmem_req; obs_we = dmem_we; obs_addr = dmem_addr;
          obs_be = dmem_be; obs_wdata = dmem_wdata;
        end else if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !==
                     {1'b1, obs_we, obs_addr, obs_be, obs_wdata}) begin
          obs_unstable = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    obs_req_post = dmem_req;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({dmem_req, dmem_we, dmem_be} !== 6'd0) begin
      n_fail++; $display("FAIL reset_ctrl: got req/we/be %b want 000000", {dmem_req, dmem_we, dmem_be});
    end
    n_cmp++;
    if ({dmem_addr, dmem_wdata} !== 64'd0) begin
      n_fail++; $display("FAIL reset_bus: got addr %h wdata %h want 0", dmem_addr, dmem_wdata);
    end
    n_cmp++;
    if ({load_data, stall, fault} !== 34'd0) begin
      n_fail++; $display("FAIL reset_out: got load_data %h stall %b fault %b want 0", load_data, stall, fault);
    end
    rst = 1'b0;
  endtask

  task automatic test_lb();
    run_access(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'd0, 32'h80FF_1234, 0, 20);
    exp_ld = 32'hFFFF_FF80;
    n_cmp++;
    if (obs_stall != 2 || !obs_done) begin
      n_fail++; $display("FAIL lb_stall: got %0d stall cycles (done %b) want 2", obs_stall, obs_done);
    end
    n_cmp++;
    if ({obs_req_seen, obs_we, obs_addr, obs_be} !== {1'b1, 1'b0, 32'h100, 4'b1000}) begin
      n_fail++; $display("FAIL lb_req: got req %b we %b addr %h be %b want 1 0 00000100 1000",
                         obs_req_seen, obs_we, obs_addr, obs_be);
    end
    n_cmp++;
    if (obs_ld !== exp_ld) begin
      n_fail++; $display("FAIL lb_data: got %h want %h", obs_ld, exp_ld);
    end
    n_cmp++;
    if ({obs_req_done, obs_req_post} !== 2'b00) begin
      n_fail++; $display("FAIL lb_reissue: got req in done %b after %b want 0 0", obs_req_done, obs_req_post);
    end
  endtask

  task automatic test_lh();
    run_access(1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'd0, 32'h8001_0000, 0, 20);
    n_cmp++;
    if (obs_ld !== 32'h0000_8001 || obs_be !== 4'b1100) begin
      n_fail++; $display("FAIL lhu_data: got %h be %b want 00008001 be 1100", obs_ld, obs_be);
    end
    run_access(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'd0, 32'h8001_0000, 0, 20);
    exp_ld = 32'hFFFF_8001;
    n_cmp++;
    if (obs_ld !== exp_ld || obs_stall != 2) begin
      n_fail++; $display("FAIL lh_data: got %h stall %0d want %h stall 2", obs_ld, obs_stall, exp_ld);
    end
  endtask

  task automatic test_sb();
    run_access(1'b0, 1'b1, 3'b000, 32'h0000_0201, 32'hAABB_CCDD, $urandom, 3, 20);
    n_cmp++;
    if ({obs_we, obs_addr, obs_be, obs_wdata} !== {1'b1, 32'h200, 4'b0010, 32'hDDDD_DDDD}) begin
      n_fail++; $display("FAIL sb_req: got we %b addr %h be %b wdata %h want 1 00000200 0010 dddddddd",
                         obs_we, obs_addr, obs_be, obs_wdata);
    end
    n_cmp++;
    if (obs_stall != 5 || !obs_done || obs_unstable) begin
      n_fail++; $display("FAIL sb_stall: got %0d stall cycles done %b unstable %b want 5 1 0",
                         obs_stall, obs_done, obs_unstable);
    end
    n_cmp++;
    if (obs_ld !== exp_ld) begin
      n_fail++; $display("FAIL sb_keep_load: got %h want %h", obs_ld, exp_ld);
    end
  endtask

  task automatic test_faults();
    for (int i = 0; i < 4; i++) begin
      bit          rd, wr;
      logic [2:0]  f3;
      logic [31:0] a;
      case (i)
        0:       begin rd = 1; wr = 0; f3 = 3'b010; a = 32'h302; end
        1:       begin rd = 1; wr = 0; f3 = 3'b011; a = 32'h100; end
        2:       begin rd = 1; wr = 1; f3 = 3'b000; a = 32'h100; end
        default: begin rd = 0; wr = 1; f3 = 3'b100; a = 32'h100; end
      endcase
      run_access(rd, wr, f3, a, $urandom, $urandom, 0, 20);
      n_cmp++;
      if ({obs_fault, obs_req_post} !== 2'b10 || obs_stall != 0) begin
        n_fail++; $display("FAIL fault_%0d: got fault %b stall %0d req %b want 1 0 0",
                           i, obs_fault, obs_stall, obs_req_post);
      end
      n_cmp++;
      if (load_data !== exp_ld) begin
        n_fail++; $display("FAIL fault_keep_%0d: got %h want %h", i, load_data, exp_ld);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++) begin
      int          sel, wt;
      bit          rd, wr, ok;
      logic [2:0]  f3;
      logic [31:0] a, d, rdat;
      sel  = $urandom_range(0, 9);
      rd   = (sel == 0) || (sel >= 2 && sel <= 5);
      wr   = (sel == 0) || (sel >= 6);
      f3   = 3'($urandom_range(0, 7));
      a    = $urandom; d = $urandom; rdat = $urandom;
      wt   = $urandom_range(0, 3);
      ok   = ref_valid(rd, wr, f3, a);
      run_access(rd, wr, f3, a, d, rdat, wt, 20);
      if (ok) begin
        if (rd) exp_ld = ref_load(rdat, f3, a);
        n_cmp++;
        if (obs_stall != 2 + wt) begin
          n_fail++; $display("FAIL rnd_stall[%0d]: got %0d want %0d", i, obs_stall, 2 + wt);
        end
        n_cmp++;
        if ({obs_we, obs_addr, obs_be, obs_wdata} !==
            {wr, a & 32'hFFFF_FFFC, ref_be(f3, a), ref_wdata(wr, f3, d)}) begin
          n_fail++; $display("FAIL rnd_req[%0d]: got we %b addr %h be %b wdata %h want %b %h %b %h",
                             i, obs_we, obs_addr, obs_be, obs_wdata, wr, a & 32'hFFFF_FFFC,
                             ref_be(f3, a), ref_wdata(wr, f3, d));
        end
        n_cmp++;
        if (obs_ld !== exp_ld) begin
          n_fail++; $display("FAIL rnd_load[%0d]: got %h want %h (f3 %b addr %h rdata %h)",
                             i, obs_ld, exp_ld, f3, a, rdat);
        end
        n_cmp++;
        if ({obs_fault, obs_done_fault, obs_req_done, obs_req_post, obs_unstable, obs_done,
             obs_req_seen} !== 7'b0000011) begin
          n_fail++; $display("FAIL rnd_flags[%0d]: got %b want 0000011", i,
                             {obs_fault, obs_done_fault, obs_req_done, obs_req_post,
                              obs_unstable, obs_done, obs_req_seen});
        end
      end else begin
        n_cmp++;
        if ({obs_fault, obs_req_post} !== {rd | wr, 1'b0} || obs_stall != 0) begin
          n_fail++; $display("FAIL rnd_reject[%0d]: got fault %b req %b stall %0d want %b 0 0",
                             i, obs_fault, obs_req_post, obs_stall, rd | wr);
        end
        n_cmp++;
        if (load_data !== exp_ld) begin
          n_fail++; $display("FAIL rnd_keep[%0d]: got %h want %h", i, load_data, exp_ld);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rdat;
    @(posedge clk); #1;
    mem_read = 1'b1; funct3 = 3'b010; alu_out = 32'h400; dmem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++;
    if (dmem_req !== 1'b1) begin
      n_fail++; $display("FAIL mid_req_up: got %b want 1", dmem_req);
    end
    rst = 1'b1;
    clear_inputs();
    #1;
    exp_ld = 32'd0;
    n_cmp++;
    if ({dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, load_data, stall, fault} !== 104'd0) begin
      n_fail++; $display("FAIL mid_reset: got req %b we %b be %b addr %h wdata %h ld %h stall %b fault %b want all 0",
                         dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, load_data, stall, fault);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    rdat = $urandom;
    run_access(1'b1, 1'b0, 3'b010, 32'h404, 32'd0, rdat, 1, 20);
    exp_ld = rdat;
    n_cmp++;
    if (obs_ld !== exp_ld || obs_stall != 3 || obs_addr !== 32'h404) begin
      n_fail++; $display("FAIL mid_after: got ld %h stall %0d addr %h want %h 3 00000404",
                         obs_ld, obs_stall, obs_addr, exp_ld);
    end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    logic [31:0] rdat;
    run_access(1'b1, 1'b0, 3'b010, 32'h500, 32'd0, $urandom, -1, 20);
    exp_ld = 32'd0;
    n_cmp++;
    if (!obs_done || obs_stall != 1 + TO || obs_req_done) begin
      n_fail++; $display("FAIL to_abort: got done %b stall %0d req %b want 1 %0d 0",
                         obs_done, obs_stall, obs_req_done, 1 + TO);
    end
    n_cmp++;
    if (obs_done_fault !== 1'b1 || obs_ld !== 32'd0) begin
      n_fail++; $display("FAIL to_fault: got fault %b ld %h want 1 00000000", obs_done_fault, obs_ld);
    end
    rdat = $urandom;
    run_access(1'b1, 1'b0, 3'b010, 32'h504, 32'd0, rdat, TO - 1, 20);
    exp_ld = rdat;
    n_cmp++;
    if (obs_done_fault !== 1'b0 || obs_ld !== exp_ld || obs_stall != 1 + TO) begin
      n_fail++; $display("FAIL to_ready_wins: got fault %b ld %h stall %0d want 0 %h %0d",
                         obs_done_fault, obs_ld, obs_stall, exp_ld, 1 + TO);
    end
  endtask
`else
  task automatic test_long_wait();
    logic [31:0] rdat;
    rdat = $urandom;
    run_access(1'b1, 1'b0, 3'b010, 32'h600, 32'd0, rdat, 30, 40);
    exp_ld = rdat;
    n_cmp++;
    if (!obs_done || obs_stall != 32 || obs_done_fault || obs_ld !== exp_ld || obs_unstable) begin
      n_fail++; $display("FAIL long_wait: got done %b stall %0d fault %b ld %h unstable %b want 1 32 0 %h 0",
                         obs_done, obs_stall, obs_done_fault, obs_ld, obs_unstable, exp_ld);
    end
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog: got still running want finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    dmem_rdata = 32'd0;
    exp_ld = 32'd0;
    test_reset();
    test_lb();
    test_lh();
    test_sb();
    test_faults();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
